// File: rtl/digdug_hiscore_xfer_if.sv
// Bus bundle between the high-score transfer engine, the host NVRAM stream
// and the fpga_digdug high-score RAM port.
//   START_LOAD/START_SAVE  : host command pulses
//   SRC_*                  : host -> core byte stream (LOAD)
//   DST_*                  : core -> host byte stream (SAVE)
//   BUSY/DONE/ERROR        : status back to the host
//   PAUSE_REQ              : ORed into the core PAUSE input
//   hs_*                   : core high-score RAM port
// master = transfer engine, slave = host/core side.
interface digdug_hiscore_xfer_if;
  logic        START_LOAD;
  logic        START_SAVE;
  logic [7:0]  SRC_DATA;
  logic        SRC_VALID;
  logic        SRC_READY;
  logic [7:0]  DST_DATA;
  logic        DST_VALID;
  logic        DST_READY;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic        PAUSE_REQ;
  logic        hs_access;
  logic [10:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;

  modport master (
    input  START_LOAD, START_SAVE, SRC_DATA, SRC_VALID, DST_READY, hs_data_out,
    output SRC_READY, DST_DATA, DST_VALID, BUSY, DONE, ERROR, PAUSE_REQ,
           hs_access, hs_address, hs_data_in, hs_write
  );

  modport slave (
    output START_LOAD, START_SAVE, SRC_DATA, SRC_VALID, DST_READY, hs_data_out,
    input  SRC_READY, DST_DATA, DST_VALID, BUSY, DONE, ERROR, PAUSE_REQ,
           hs_access, hs_address, hs_data_in, hs_write
  );
endinterface

// File: rtl/digdug_hiscore_xfer.sv
// digdug_hiscore_xfer: initiator for the Dig Dug high-score RAM port.
// LOAD copies a host byte stream into core RAM, SAVE streams core RAM back
// to the host. The core is held paused (PAUSE_REQ) and the RAM port granted
// (hs_access) continuously from acquisition through the last access.
// Ports:
//   MCLK   master clock
//   RESET  asynchronous, active-high
//   bus    digdug_hiscore_xfer_if.master (host streams, status, hs_* port)
// Parameters: BASE_ADDR (window start), LENGTH (bytes, 1..2048),
//   SETTLE (cycles in ACQ before first access), RD_LAT (1..3).
// Optional feature macro HS_CHECKSUM_EN: appends an 8-bit checksum trailer
// (~sum of data bytes) to SAVE and checks one on LOAD, flagging ERROR.
module digdug_hiscore_xfer #(
  parameter logic [10:0] BASE_ADDR = 11'h000,
  parameter int          LENGTH    = 64,
  parameter logic [3:0]  SETTLE    = 4'd4,
  parameter logic [1:0]  RD_LAT    = 2'd2
) (
  input logic                    MCLK,
  input logic                    RESET,
  digdug_hiscore_xfer_if.master  bus
);

`ifdef HS_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam logic [11:0] LEN = 12'(LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_LD_WAIT, S_LD_WR, S_RD_WAIT, S_RD_OUT, S_REL
  } state_t;

  state_t      state, state_nx;
  logic        mode_ld;
  logic        ck_phase;   // data bytes done, now on the checksum beat
  logic [11:0] cnt;
  logic [10:0] addr;       // wraps 2047 -> 0 naturally
  logic [3:0]  tmr;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic [7:0]  sum;

  logic start_any, src_hs, dst_hs, last_beat, settle_done, lat_done;

  assign start_any   = bus.START_LOAD | bus.START_SAVE;
  assign src_hs      = (state == S_LD_WAIT) & bus.SRC_VALID;
  assign dst_hs      = (state == S_RD_OUT) & bus.DST_READY;
  assign last_beat   = (cnt + 12'd1) == LEN;
  // >= so a zero parameter behaves as one cycle rather than hanging
  assign settle_done = ({1'b0, tmr} + 5'd1) >= {1'b0, SETTLE};
  // hs_data_out is taken on the RD_LAT-th MCLK edge after hs_address moved
  assign lat_done    = (tmr + 4'd1) >= {2'b00, RD_LAT};

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start_any) state_nx = S_ACQ;
      S_ACQ:     if (settle_done) state_nx = mode_ld ? S_LD_WAIT : S_RD_WAIT;
      S_LD_WAIT: if (src_hs) state_nx = ck_phase ? S_REL : S_LD_WR;
      S_LD_WR:   state_nx = (last_beat && !CK) ? S_REL : S_LD_WAIT;
      S_RD_WAIT: if (lat_done) state_nx = S_RD_OUT;
      S_RD_OUT: begin
        if (dst_hs) begin
          if (ck_phase)       state_nx = S_REL;
          else if (last_beat) state_nx = CK ? S_RD_OUT : S_REL;
          else                state_nx = S_RD_WAIT;
        end
      end
      S_REL:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      mode_ld  <= 1'b0;
      ck_phase <= 1'b0;
      cnt      <= '0;
      addr     <= BASE_ADDR;
      tmr      <= '0;
      wr_byte  <= '0;
      rd_byte  <= '0;
      sum      <= '0;
    end else begin
      // tmr only means something in ACQ/RD_WAIT; it restarts on every entry
      tmr <= (state_nx != state) ? 4'd0 : tmr + 4'd1;
      case (state)
        S_IDLE: if (start_any) begin
          mode_ld  <= bus.START_LOAD;   // LOAD wins a simultaneous start
          ck_phase <= 1'b0;
          cnt      <= '0;
          addr     <= BASE_ADDR;
          sum      <= '0;
        end
        S_LD_WAIT: if (src_hs) begin
          wr_byte <= bus.SRC_DATA;
          if (!ck_phase) sum <= sum + bus.SRC_DATA;
        end
        S_LD_WR: begin
          cnt  <= cnt + 12'd1;
          addr <= addr + 11'd1;
          if (CK && last_beat) ck_phase <= 1'b1;
        end
        S_RD_WAIT: if (lat_done) begin
          rd_byte <= bus.hs_data_out;
          sum     <= sum + bus.hs_data_out;
        end
        S_RD_OUT: if (dst_hs && !ck_phase) begin
          cnt  <= cnt + 12'd1;
          addr <= addr + 11'd1;
          // sum already holds the last data byte here; the trailer is not a core read
          if (CK && last_beat) begin
            ck_phase <= 1'b1;
            rd_byte  <= ~sum;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HS_CHECKSUM_EN
  logic err;
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)                          err <= 1'b0;
    else if (state == S_IDLE && start_any) err <= 1'b0;
    else if (src_hs && ck_phase)        err <= (sum + bus.SRC_DATA) != 8'hFF;
  end
  assign bus.ERROR = err;
`else
  assign bus.ERROR = 1'b0;
`endif

  // Strobes decode straight from the state register so RESET drops them at once
  assign bus.BUSY       = state != S_IDLE;
  assign bus.DONE       = state == S_REL;
  assign bus.hs_access  = (state != S_IDLE) && (state != S_REL);
  assign bus.PAUSE_REQ  = bus.hs_access;
  assign bus.SRC_READY  = state == S_LD_WAIT;
  assign bus.DST_VALID  = state == S_RD_OUT;
  assign bus.hs_write   = state == S_LD_WR;
  assign bus.hs_data_in = wr_byte;
  assign bus.hs_address = addr;
  assign bus.DST_DATA   = rd_byte;

endmodule
